// File: rtl/frame_serializer_pkg.sv
// Shared types and sizing helpers for the frame serializer.
// FRAME_SERIALIZER_PARITY_EN adds a trailing per-lane parity beat to every word.
package frame_serializer_pkg;

`ifdef FRAME_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PARITY} state_t;
  localparam int PARITY_BEATS = 1;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT} state_t;
  localparam int PARITY_BEATS = 0;
`endif

  function automatic int beats_per_word(input int data_size, input int lanes);
    return data_size / lanes + PARITY_BEATS;
  endfunction

  function automatic int cnt_width(input int data_size, input int lanes);
    return $clog2(beats_per_word(data_size, lanes) + 1);
  endfunction

endpackage

// File: rtl/frame_serializer_if.sv
// Parallel-word load handshake between a word producer and the serializer.
interface frame_serializer_if #(
  parameter int DATA_SIZE = 64
);
  logic [DATA_SIZE-1:0] data_in;
  logic                 load_valid;
  logic                 load_ready;

  modport master (output data_in, load_valid, input load_ready);
  modport slave  (input data_in, load_valid, output load_ready);
endinterface

// File: rtl/serializer_hold_buffer.sv
// One-word holding buffer; owns the load handshake and parks a word while the shifter is busy.
module serializer_hold_buffer #(
  parameter int DATA_SIZE = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  frame_serializer_if.slave    ld,
  input  logic                 s_idle,
  input  logic                 pop,
  output logic                 accept,
  output logic                 full,
  output logic [DATA_SIZE-1:0] data
);
  // Ready drops combinationally with reset so nothing is accepted while held in reset.
  assign ld.load_ready = rst_n && !full;
  assign accept        = ld.load_valid && ld.load_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      data <= '0;
    end else if (pop) begin
      full <= 1'b0;
    end else if (accept && !s_idle) begin
      full <= 1'b1;
      data <= ld.data_in;
    end
  end
endmodule

// File: rtl/frame_serializer.sv
// Parallel-to-serial word shifter, LANES bits per beat, gapless reload from a holding buffer.
// FRAME_SERIALIZER_PARITY_EN appends one XOR-parity beat per word.
module frame_serializer
  import frame_serializer_pkg::*;
#(
  parameter int DATA_SIZE = 64,
  parameter int LANES     = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [DATA_SIZE-1:0] DATA_IN,
  input  logic                 LOAD_VALID,
  output logic                 LOAD_READY,
  input  logic                 SHIFT_EN,
  output logic [LANES-1:0]     DATA,
  output logic                 DATA_VALID,
  output logic                 FRAME_START,
  output logic                 FRAME_END,
  output logic                 BUSY
);
  localparam int            B_DATA = DATA_SIZE / LANES;
  localparam int            CW     = cnt_width(DATA_SIZE, LANES);
  localparam logic [CW-1:0] LAST   = CW'(B_DATA - 1);

  generate
    if (DATA_SIZE % LANES != 0) begin : g_bad_lanes
      $error("frame_serializer: DATA_SIZE must be a multiple of LANES");
    end
  endgenerate

  frame_serializer_if #(.DATA_SIZE(DATA_SIZE)) ld ();
  assign ld.data_in    = DATA_IN;
  assign ld.load_valid = LOAD_VALID;
  assign LOAD_READY    = ld.load_ready;

  state_t               state;
  logic [DATA_SIZE-1:0] sreg;
  logic [CW-1:0]        cnt;
  logic [DATA_SIZE-1:0] h_data;
  logic [LANES-1:0]     slice;
  logic                 accept, h_full, s_idle, last_beat, pop;

  serializer_hold_buffer #(.DATA_SIZE(DATA_SIZE)) u_hold (
    .clk    (CLK),
    .rst_n  (RST_N),
    .ld     (ld),
    .s_idle (s_idle),
    .pop    (pop),
    .accept (accept),
    .full   (h_full),
    .data   (h_data)
  );

  assign s_idle = (state == ST_IDLE);
  assign slice  = (MSB_FIRST != 0) ? sreg[DATA_SIZE-1 -: LANES] : sreg[LANES-1:0];
  assign BUSY   = !s_idle || h_full;

`ifdef FRAME_SERIALIZER_PARITY_EN
  logic [LANES-1:0] par;
  assign last_beat = SHIFT_EN && (state == ST_PARITY);
`else
  assign last_beat = SHIFT_EN && (state == ST_SHIFT) && (cnt == LAST);
`endif

  // H drains either on the final beat (gapless reload) or when S went idle with a word parked.
  assign pop = (last_beat && h_full) || (s_idle && h_full);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      sreg        <= '0;
      cnt         <= '0;
      DATA        <= '0;
      DATA_VALID  <= 1'b0;
      FRAME_START <= 1'b0;
      FRAME_END   <= 1'b0;
`ifdef FRAME_SERIALIZER_PARITY_EN
      par         <= '0;
`endif
    end else begin
      DATA_VALID  <= 1'b0;
      FRAME_START <= 1'b0;
      FRAME_END   <= 1'b0;
      if (SHIFT_EN) begin
        case (state)
          ST_IDLE: DATA <= '0;
          ST_SHIFT: begin
            DATA        <= slice;
            DATA_VALID  <= 1'b1;
            FRAME_START <= (cnt == '0);
            sreg        <= (MSB_FIRST != 0) ? (sreg << LANES) : (sreg >> LANES);
            cnt         <= cnt + CW'(1);
`ifdef FRAME_SERIALIZER_PARITY_EN
            par         <= (cnt == '0) ? slice : (par ^ slice);
            if (cnt == LAST) state <= ST_PARITY;
`else
            FRAME_END   <= (cnt == LAST);
`endif
          end
`ifdef FRAME_SERIALIZER_PARITY_EN
          ST_PARITY: begin
            DATA       <= par;
            DATA_VALID <= 1'b1;
            FRAME_END  <= 1'b1;
          end
`endif
          default: ;
        endcase
        if (last_beat) begin
          if (h_full) begin
            sreg  <= h_data;
            cnt   <= '0;
            state <= ST_SHIFT;
          end else begin
            state <= ST_IDLE;
          end
        end
      end
      // Idle shifter takes a parked word first, otherwise a freshly accepted one.
      if (s_idle && (accept || h_full)) begin
        sreg  <= h_full ? h_data : DATA_IN;
        cnt   <= '0;
        state <= ST_SHIFT;
      end
    end
  end
endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench: two serializer configs (8b x1 MSB-first, 8b x2 LSB-first) with hand-computed beats.
module tb_frame_serializer;
`ifdef FRAME_SERIALIZER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NB1 = PAR ? 9 : 8;
  localparam int NB2 = PAR ? 5 : 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       se1 = 1'b0, se2 = 1'b0;
  logic [0:0] data1;
  logic       dv1, fs1, fe1, busy1;
  logic [1:0] data2;
  logic       dv2, fs2, fe2, busy2;
  int         checks = 0;
  int         errors = 0;

  frame_serializer_if #(.DATA_SIZE(8)) b1 ();
  frame_serializer_if #(.DATA_SIZE(8)) b2 ();

  always #5 clk = ~clk;

  frame_serializer #(.DATA_SIZE(8), .LANES(1), .MSB_FIRST(1)) u1 (
    .CLK(clk), .RST_N(rst_n), .DATA_IN(b1.data_in), .LOAD_VALID(b1.load_valid),
    .LOAD_READY(b1.load_ready), .SHIFT_EN(se1), .DATA(data1), .DATA_VALID(dv1),
    .FRAME_START(fs1), .FRAME_END(fe1), .BUSY(busy1)
  );

  frame_serializer #(.DATA_SIZE(8), .LANES(2), .MSB_FIRST(0)) u2 (
    .CLK(clk), .RST_N(rst_n), .DATA_IN(b2.data_in), .LOAD_VALID(b2.load_valid),
    .LOAD_READY(b2.load_ready), .SHIFT_EN(se2), .DATA(data2), .DATA_VALID(dv2),
    .FRAME_START(fs2), .FRAME_END(fe2), .BUSY(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_bit1(input logic [7:0] w, input int k);
    return (k < 8) ? w[7-k] : ^w;
  endfunction

  // Checks beats k0..k1 of word w on u1; rdy is the expected LOAD_READY before the final beat.
  task automatic beats1(input logic [7:0] w, input int k0, input int k1, input logic rdy);
    for (int k = k0; k <= k1; k++) begin
      tick();
      b1.load_valid = 1'b0;
      chk($sformatf("w%02h_b%0d_data", w, k), {31'b0, data1}, {31'b0, exp_bit1(w, k)});
      chk($sformatf("w%02h_b%0d_valid", w, k), {31'b0, dv1}, 32'd1);
      chk($sformatf("w%02h_b%0d_start", w, k), {31'b0, fs1}, {31'b0, (k == 0)});
      chk($sformatf("w%02h_b%0d_end", w, k), {31'b0, fe1}, {31'b0, (k == NB1-1)});
      chk($sformatf("w%02h_b%0d_ready", w, k), {31'b0, b1.load_ready},
          {31'b0, (k == NB1-1) ? 1'b1 : rdy});
    end
  endtask

  initial begin
    logic [1:0] e2 [5];
    e2 = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
    b1.data_in = 8'h00; b1.load_valid = 1'b0;
    b2.data_in = 8'h00; b2.load_valid = 1'b0;

    // reset values
    #12;
    chk("rst_data", {31'b0, data1}, 32'd0);
    chk("rst_valid", {31'b0, dv1}, 32'd0);
    chk("rst_start", {31'b0, fs1}, 32'd0);
    chk("rst_end", {31'b0, fe1}, 32'd0);
    chk("rst_busy", {31'b0, busy1}, 32'd0);
    chk("rst_ready1", {31'b0, b1.load_ready}, 32'd0);
    chk("rst_ready2", {31'b0, b2.load_ready}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready1", {31'b0, b1.load_ready}, 32'd1);
    chk("post_rst_ready2", {31'b0, b2.load_ready}, 32'd1);

    // single word 0xA5, MSB first
    b1.data_in = 8'hA5; b1.load_valid = 1'b1; se1 = 1'b1;
    tick();
    b1.load_valid = 1'b0;
    chk("a5_load_valid", {31'b0, dv1}, 32'd0);
    chk("a5_load_busy", {31'b0, busy1}, 32'd1);
    beats1(8'hA5, 0, NB1-1, 1'b1);
    tick();
    chk("a5_after_valid", {31'b0, dv1}, 32'd0);
    chk("a5_after_data", {31'b0, data1}, 32'd0);
    chk("a5_after_busy", {31'b0, busy1}, 32'd0);

    // 2 lanes, LSB first, 0xB4
    b2.data_in = 8'hB4; b2.load_valid = 1'b1; se2 = 1'b1;
    tick();
    b2.load_valid = 1'b0;
    chk("b4_load_valid", {31'b0, dv2}, 32'd0);
    for (int k = 0; k < NB2; k++) begin
      tick();
      chk($sformatf("b4_b%0d_data", k), {30'b0, data2}, {30'b0, e2[k]});
      chk($sformatf("b4_b%0d_valid", k), {31'b0, dv2}, 32'd1);
      chk($sformatf("b4_b%0d_start", k), {31'b0, fs2}, {31'b0, (k == 0)});
      chk($sformatf("b4_b%0d_end", k), {31'b0, fe2}, {31'b0, (k == NB2-1)});
    end
    tick();
    chk("b4_after_valid", {31'b0, dv2}, 32'd0);
    chk("b4_after_busy", {31'b0, busy2}, 32'd0);
    se2 = 1'b0;

    // back-to-back 0xA5 then 0x3C through the holding buffer
    b1.data_in = 8'hA5; b1.load_valid = 1'b1;
    tick();
    b1.data_in = 8'h3C; b1.load_valid = 1'b1;
    beats1(8'hA5, 0, NB1-1, 1'b0);
    chk("b2b_mid_busy", {31'b0, busy1}, 32'd1);
    beats1(8'h3C, 0, NB1-1, 1'b1);
    tick();
    chk("b2b_after_valid", {31'b0, dv1}, 32'd0);
    chk("b2b_after_busy", {31'b0, busy1}, 32'd0);

    // stall for 3 cycles after beat 2
    b1.data_in = 8'hA5; b1.load_valid = 1'b1;
    tick();
    b1.load_valid = 1'b0;
    beats1(8'hA5, 0, 2, 1'b1);
    se1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d_valid", i), {31'b0, dv1}, 32'd0);
      chk($sformatf("stall%0d_start", i), {31'b0, fs1}, 32'd0);
      chk($sformatf("stall%0d_end", i), {31'b0, fe1}, 32'd0);
      chk($sformatf("stall%0d_data", i), {31'b0, data1}, 32'd1);
      chk($sformatf("stall%0d_busy", i), {31'b0, busy1}, 32'd1);
    end
    se1 = 1'b1;
    beats1(8'hA5, 3, NB1-1, 1'b1);
    tick();
    chk("stall_after_valid", {31'b0, dv1}, 32'd0);

    // reset mid-word with H full
    b1.data_in = 8'hA5; b1.load_valid = 1'b1;
    tick();
    b1.data_in = 8'h3C; b1.load_valid = 1'b1;
    beats1(8'hA5, 0, 4, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_data", {31'b0, data1}, 32'd0);
    chk("mid_rst_valid", {31'b0, dv1}, 32'd0);
    chk("mid_rst_start", {31'b0, fs1}, 32'd0);
    chk("mid_rst_end", {31'b0, fe1}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy1}, 32'd0);
    chk("mid_rst_ready", {31'b0, b1.load_ready}, 32'd0);
    tick();
    chk("mid_rst_hold_valid", {31'b0, dv1}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("rel_ready", {31'b0, b1.load_ready}, 32'd1);
    chk("rel_busy", {31'b0, busy1}, 32'd0);
    chk("rel_valid", {31'b0, dv1}, 32'd0);
    chk("rel_end", {31'b0, fe1}, 32'd0);
    b1.data_in = 8'hFF; b1.load_valid = 1'b1;
    tick();
    b1.load_valid = 1'b0;
    beats1(8'hFF, 0, NB1-1, 1'b1);
    tick();
    chk("ff_after_valid", {31'b0, dv1}, 32'd0);
    chk("ff_after_busy", {31'b0, busy1}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
